nand_gate_sweeper: RTL and testbench
====================================

Name: nand_gate_sweeper

Overview:
- Parametrised, self-checking successor to the two-input NAND-built OR gate.
- Contains an N_IN-input gate network built only from 2-input nand primitives, with the gate function selectable as OR, AND, NOR or XOR.
- A sweep FSM applies every input combination 0..2^N_IN-1 in turn, samples the NAND network, compares it against a behavioural golden result and counts mismatches.
- Used as the lab's automated truth-table generator/checker in place of hand-written stimulus blocks.

Parameters:
- N_IN, 2, number of gate inputs; legal range 2..8.
- CNT_W, N_IN+1, width of the mismatch counter; holds the 2^N_IN worst case without saturation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when IDLE.
- mode  input  2  gate function: 00 OR, 01 AND, 10 NOR, 11 XOR.
- busy  output  1  high from APPLY through DONE.
- vec  output  N_IN  input vector currently driven into the NAND network.
- z  output  1  registered NAND-network result for the last sampled vec.
- z_exp  output  1  registered golden result for the last sampled vec.
- err_cnt  output  CNT_W  mismatches in the current/last sweep.
- first_err_vec  output  N_IN  vec of the first mismatch in the sweep.
- err_flag  output  1  set on first mismatch; held until next start.
- done  output  1  one-cycle pulse at sweep end.

Behaviour:
- Reset values:
  - State IDLE.
  - busy, z, z_exp, err_flag and done are 0.
  - vec, err_cnt and first_err_vec are all-zero.
- Reset is asynchronous. Asserting it mid-sweep aborts immediately, with no done pulse.
- NAND network:
  - Purely structural nand instances, N_IN-input trees.
  - OR = NAND of the inverted inputs, where each inverter is nand(a,a).
  - AND = nand inverted.
  - NOR = OR inverted.
  - XOR = standard 4-NAND cell chained across the inputs.
  - The golden model is behavioural: |vec, &vec, ~|vec, ^vec.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1: latch mode into mode_q, clear err_cnt/err_flag/first_err_vec, set vec=0, go to APPLY.
  - start=0: stay in IDLE. All outputs hold, so results remain readable after a sweep.
- APPLY: vec is stable and the network settles. Always go to SAMPLE next cycle.
- SAMPLE:
  - Register z and z_exp from the current vec and mode_q.
  - On z != z_exp: increment err_cnt. If err_flag=0, also set err_flag=1 and first_err_vec=vec.
  - If vec == 2^N_IN-1: go to DONE and vec holds.
  - Otherwise: vec increments and the FSM returns to APPLY.
- DONE: done=1 for exactly this cycle, busy=1. Go to IDLE next cycle.
- Timing, with start sampled at cycle 0:
  - SAMPLE for vector k occurs at cycle 2k+2.
  - done is high at cycle 2^(N_IN+1)+1.
  - For N_IN=2, done is high at cycle 9.
- busy is 1 in APPLY, SAMPLE and DONE.
- start is ignored while busy, including a start arriving on the DONE cycle.
- Changes to mode during a sweep are ignored; mode_q is used.
- err_cnt never wraps, because CNT_W = N_IN+1 bits and the maximum count is 2^N_IN.

Optional Feature:
- Macro: NAND_SWEEP_FAULT_INJECT_EN.
- Defined:
  - Adds input port fault_vec (N_IN bits) and fault_en (1 bit).
  - When fault_en=1 and vec==fault_vec, the NAND network output is inverted before sampling.
  - Proves the checker detects mismatches.
- Undefined: the ports do not exist and the network output is never altered.

Test Plan:
- rst_n=0 mid-sweep at cycle 5 -> all outputs return to reset values asynchronously; no done pulse; the next start runs a full clean sweep.
- N_IN=2, mode=00, start -> vec sequence 0,1,2,3; z per vec 0,1,1,1; done at cycle 9; err_cnt=0; err_flag=0.
- N_IN=3, mode=11, start -> z per vec 0,1,1,0,1,0,0,1; done at cycle 17; err_cnt=0.
- N_IN=2, mode=01, then mode=10 driven at cycle 3; start pulsed again at cycle 4 -> sweep completes as AND (z=0,0,0,1); second start ignored; busy low at cycle 10.
- With NAND_SWEEP_FAULT_INJECT_EN: N_IN=2, mode=10, fault_en=1, fault_vec=2 -> err_cnt=1, err_flag=1, first_err_vec=2, z=1 while z_exp=0 at vec 2.
- Back-to-back sweeps, with start pulsed on the cycle after done -> the second sweep clears err_cnt/err_flag at start, and the first sweep's results persist until then.

Source files
------------

// File: rtl/nand_gate_sweeper.sv
// nand_gate_sweeper
//   Exhaustive truth-table checker for an N_IN-input gate network built only
//   from 2-input nand primitives. The function is selected as OR, AND, NOR or XOR.
//   A sweep FSM (IDLE -> APPLY -> SAMPLE ... -> DONE) drives every vector
//   0..2^N_IN-1 into the network. It compares each result against a behavioural
//   golden model and counts the mismatches.
// Optional macro: NAND_SWEEP_FAULT_INJECT_EN adds fault_vec/fault_en, which
//   invert the network output when vec matches fault_vec.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, mode     sweep start pulse; 00 OR, 01 AND, 10 NOR, 11 XOR
//   busy, done      sweep in progress; one-cycle end pulse
//   vec             vector currently driven into the network
//   z, z_exp        registered network / golden result of the last sample
//   err_cnt, err_flag, first_err_vec   mismatch statistics of the sweep
module nand_gate_sweeper #(
   parameter int N_IN  = 2,
   parameter int CNT_W = N_IN + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
`ifdef NAND_SWEEP_FAULT_INJECT_EN
   input  logic [N_IN-1:0]  fault_vec,
   input  logic             fault_en,
`endif
   output logic             busy,
   output logic [N_IN-1:0]  vec,
   output logic             z,
   output logic             z_exp,
   output logic [CNT_W-1:0] err_cnt,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             err_flag,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [N_IN-1:0]  r_vec;
   logic [N_IN-1:0]  r_first;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_busy, r_z, r_z_exp, r_err_flag, r_done;

   // ---------------- structural NAND network ----------------
   wire [N_IN-1:0] w_inv;      // nand(a,a) inverters
   wire [N_IN-1:0] w_or_acc;   // running AND of inverted inputs
   wire [N_IN-1:0] w_and_acc;  // running AND of true inputs
   wire [N_IN-1:0] w_xor_acc;  // running XOR
   wire [N_IN-1:1] w_or_t, w_and_t, w_xm, w_xp, w_xq;
   wire            w_or, w_nor;

   assign w_or_acc[0]  = w_inv[0];
   assign w_and_acc[0] = r_vec[0];
   assign w_xor_acc[0] = r_vec[0];

   for (genvar i = 0; i < N_IN; i++) begin : g_inv
      nand u_inv (w_inv[i], r_vec[i], r_vec[i]);
   end

   for (genvar i = 1; i < N_IN; i++) begin : g_chain
      // AND stage: nand followed by nand-inverter
      nand u_ot (w_or_t[i],    w_or_acc[i-1],  w_inv[i]);
      nand u_oa (w_or_acc[i],  w_or_t[i],      w_or_t[i]);
      nand u_at (w_and_t[i],   w_and_acc[i-1], r_vec[i]);
      nand u_aa (w_and_acc[i], w_and_t[i],     w_and_t[i]);
      // classic 4-NAND XOR cell
      nand u_xm (w_xm[i],      w_xor_acc[i-1], r_vec[i]);
      nand u_xp (w_xp[i],      w_xor_acc[i-1], w_xm[i]);
      nand u_xq (w_xq[i],      r_vec[i],       w_xm[i]);
      nand u_xo (w_xor_acc[i], w_xp[i],        w_xq[i]);
   end

   // OR = NAND of all inverted inputs; NOR = OR inverted
   nand u_or  (w_or,  w_or_acc[N_IN-1], w_or_acc[N_IN-1]);
   nand u_nor (w_nor, w_or, w_or);

   logic w_net, w_z_net, w_gold;

   always_comb begin
      w_net = w_or;
      case (r_mode)
         2'b00:   w_net = w_or;
         2'b01:   w_net = w_and_acc[N_IN-1];
         2'b10:   w_net = w_nor;
         default: w_net = w_xor_acc[N_IN-1];
      endcase
   end

`ifdef NAND_SWEEP_FAULT_INJECT_EN
   assign w_z_net = w_net ^ (fault_en && (r_vec == fault_vec));
`else
   assign w_z_net = w_net;
`endif

   always_comb begin
      w_gold = |r_vec;
      case (r_mode)
         2'b00:   w_gold = |r_vec;
         2'b01:   w_gold = &r_vec;
         2'b10:   w_gold = ~|r_vec;
         default: w_gold = ^r_vec;
      endcase
   end

   // ---------------- sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_mode     <= 2'b00;
         r_vec      <= '0;
         r_first    <= '0;
         r_err_cnt  <= '0;
         r_busy     <= 1'b0;
         r_z        <= 1'b0;
         r_z_exp    <= 1'b0;
         r_err_flag <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode     <= mode;
                  r_err_cnt  <= '0;
                  r_err_flag <= 1'b0;
                  r_first    <= '0;
                  r_vec      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_APPLY;
               end
            end
            S_APPLY: r_state <= S_SAMPLE;
            S_SAMPLE: begin
               r_z     <= w_z_net;
               r_z_exp <= w_gold;
               if (w_z_net != w_gold) begin
                  r_err_cnt <= r_err_cnt + CNT_W'(1);
                  if (!r_err_flag) begin
                     r_err_flag <= 1'b1;
                     r_first    <= r_vec;
                  end
               end
               if (&r_vec) begin
                  // done is registered here so that it is high during DONE
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_vec   <= r_vec + N_IN'(1);
                  r_state <= S_APPLY;
               end
            end
            S_DONE: begin
               // any start seen here is dropped; IDLE needs a fresh one
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy          = r_busy;
   assign vec           = r_vec;
   assign z             = r_z;
   assign z_exp         = r_z_exp;
   assign err_cnt       = r_err_cnt;
   assign first_err_vec = r_first;
   assign err_flag      = r_err_flag;
   assign done          = r_done;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
module tb_nand_gate_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // N_IN=2 instance
   logic       start2 = 1'b0, busy2, z2, zexp2, ef2, done2;
   logic [1:0] mode2 = 2'b00, vec2, fev2;
   logic [2:0] cnt2;
   // N_IN=3 instance
   logic       start3 = 1'b0, busy3, z3, zexp3, ef3, done3;
   logic [1:0] mode3 = 2'b00;
   logic [2:0] vec3, fev3;
   logic [3:0] cnt3;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
   logic [1:0] fvec2 = '0;
   logic [2:0] fvec3 = '0;
   logic       fen2 = 1'b0, fen3 = 1'b0;
`endif

   nand_gate_sweeper #(.N_IN(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
`ifdef NAND_SWEEP_FAULT_INJECT_EN
      .fault_vec(fvec2), .fault_en(fen2),
`endif
      .busy(busy2), .vec(vec2), .z(z2), .z_exp(zexp2), .err_cnt(cnt2),
      .first_err_vec(fev2), .err_flag(ef2), .done(done2));

   nand_gate_sweeper #(.N_IN(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
`ifdef NAND_SWEEP_FAULT_INJECT_EN
      .fault_vec(fvec3), .fault_en(fen3),
`endif
      .busy(busy3), .vec(vec3), .z(z3), .z_exp(zexp3), .err_cnt(cnt3),
      .first_err_vec(fev3), .err_flag(ef3), .done(done3));

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // reference: gate function from the count of ones in the vector
   function automatic logic gold(input logic [1:0] m, input int v, input int n);
      int ones;
      ones = $countones(v);
      case (m)
         2'b00:   return ones != 0;
         2'b01:   return ones == n;
         2'b10:   return ones == 0;
         default: return (ones % 2) == 1;
      endcase
   endfunction

   logic       o_busy, o_z, o_zx, o_ef, o_done;
   logic [7:0] o_vec, o_cnt, o_fev;

   task automatic obs(input int d);
      if (d == 2) begin
         o_busy = busy2; o_vec = {6'b0, vec2}; o_z = z2; o_zx = zexp2;
         o_cnt = {5'b0, cnt2}; o_fev = {6'b0, fev2}; o_ef = ef2; o_done = done2;
      end else begin
         o_busy = busy3; o_vec = {5'b0, vec3}; o_z = z3; o_zx = zexp3;
         o_cnt = {4'b0, cnt3}; o_fev = {5'b0, fev3}; o_ef = ef3; o_done = done3;
      end
   endtask

   task automatic drive(input int d, input logic s, input logic [1:0] m);
      if (d == 2) begin start2 = s; mode2 = m; end
      else        begin start3 = s; mode3 = m; end
   endtask

   task automatic set_fault(input int d, input logic fen, input logic [7:0] fv);
`ifdef NAND_SWEEP_FAULT_INJECT_EN
      if (d == 2) begin fen2 = fen; fvec2 = fv[1:0]; end
      else        begin fen3 = fen; fvec3 = fv[2:0]; end
`else
      if (fen || (fv != 8'd0)) $display("note: fault injection not built in (d=%0d)", d);
`endif
   endtask

   task automatic chk_reset(input int d, input string tag);
      obs(d);
      chk($sformatf("%s busy d%0d", tag, d), o_busy, 0);
      chk($sformatf("%s vec d%0d", tag, d), o_vec, 0);
      chk($sformatf("%s z d%0d", tag, d), o_z, 0);
      chk($sformatf("%s z_exp d%0d", tag, d), o_zx, 0);
      chk($sformatf("%s err_cnt d%0d", tag, d), o_cnt, 0);
      chk($sformatf("%s first_err d%0d", tag, d), o_fev, 0);
      chk($sformatf("%s err_flag d%0d", tag, d), o_ef, 0);
      chk($sformatf("%s done d%0d", tag, d), o_done, 0);
   endtask

   // Called at a negedge: that cycle is cycle 0 (start high). Returns at the
   // negedge of cycle dcyc+1 (first IDLE cycle after done).
   // nmode: 0 quiet, 1 random start/mode noise, 2 mode->10 at c3 and start at c4
   task automatic run_sweep(input int d, input logic [1:0] m, input logic [7:0] zpat,
                            input int dcyc, input int nmode,
                            input logic fen, input logic [7:0] fvec);
      int last, k, ecnt, efirst;
      logic [1:0] cur;
      logic ez [256];
      logic eg [256];
      last = (1 << d) - 1;
      ecnt = 0; efirst = 0;
      for (int v = 0; v <= last; v++) begin
         eg[v] = gold(m, v, d);
         ez[v] = zpat[v] ^ (fen && (v == int'(fvec)));
         if (ez[v] != eg[v]) begin
            if (ecnt == 0) efirst = v;
            ecnt++;
         end
      end
      set_fault(d, fen, fvec);
      cur = m;
      drive(d, 1'b1, cur);
      @(negedge clk);
      for (int c = 1; c <= dcyc + 1; c++) begin
         obs(d);
         chk($sformatf("busy d%0d m%0d c%0d", d, m, c), o_busy, (c <= dcyc));
         chk($sformatf("done d%0d m%0d c%0d", d, m, c), o_done, (c == dcyc));
         if (c == 1) begin
            chk($sformatf("cleared err_cnt d%0d", d), o_cnt, 0);
            chk($sformatf("cleared err_flag d%0d", d), o_ef, 0);
         end
         k = (c - 1) / 2;
         if (k > last) k = last;
         chk($sformatf("vec d%0d m%0d c%0d", d, m, c), o_vec, k);
         if (c >= 3 && (c % 2) == 1 && c <= dcyc) begin
            k = (c - 3) / 2;
            chk($sformatf("z d%0d m%0d vec%0d", d, m, k), o_z, ez[k]);
            chk($sformatf("z_exp d%0d m%0d vec%0d", d, m, k), o_zx, eg[k]);
         end
         if (c >= dcyc) begin
            chk($sformatf("err_cnt d%0d m%0d c%0d", d, m, c), o_cnt, ecnt);
            chk($sformatf("err_flag d%0d m%0d c%0d", d, m, c), o_ef, (ecnt != 0));
            chk($sformatf("first_err d%0d m%0d c%0d", d, m, c), o_fev, efirst);
         end
         if (c == dcyc + 1)
            chk($sformatf("z persist d%0d m%0d", d, m), o_z, ez[last]);
         // inputs for cycle c
         if (c > dcyc) drive(d, 1'b0, m);
         else if (nmode == 1) drive(d, ($urandom_range(0, 2) == 0), 2'($urandom));
         else if (nmode == 2) begin
            if (c == 3) cur = 2'b10;
            drive(d, (c == 4), cur);
         end else drive(d, 1'b0, cur);
         if (c <= dcyc) @(negedge clk);
      end
      set_fault(d, 1'b0, 8'd0);
   endtask

   typedef struct {
      int         d;
      logic [1:0] m;
      logic [7:0] zpat;   // bit v = expected network output for vector v
      int         dcyc;
   } vec_t;

   initial begin
      vec_t tbl [6];
      int d, nm;
      logic [1:0] m;
      logic [7:0] zp, fv;
      logic fen;

      tbl[0] = '{2, 2'b00, 8'b0000_1110, 9};
      tbl[1] = '{2, 2'b01, 8'b0000_1000, 9};
      tbl[2] = '{2, 2'b10, 8'b0000_0001, 9};
      tbl[3] = '{2, 2'b11, 8'b0000_0110, 9};
      tbl[4] = '{3, 2'b11, 8'b1001_0110, 17};
      tbl[5] = '{3, 2'b00, 8'b1111_1110, 17};

      // reset values
      repeat (2) @(negedge clk);
      chk_reset(2, "por");
      chk_reset(3, "por");
      rst_n = 1'b1;
      @(negedge clk);

      // async reset at cycle 5 aborts the sweep with no done pulse
      drive(2, 1'b1, 2'b00);
      @(negedge clk);
      drive(2, 1'b0, 2'b00);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset(2, "abort");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         obs(2);
         chk("abort no done", o_done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // table of directed sweeps, then one back-to-back restart
      foreach (tbl[i]) begin
         run_sweep(tbl[i].d, tbl[i].m, tbl[i].zpat, tbl[i].dcyc, 0, 1'b0, 8'd0);
         @(negedge clk);
      end
      run_sweep(2, 2'b00, 8'b0000_1110, 9, 0, 1'b0, 8'd0);
      run_sweep(2, 2'b11, 8'b0000_0110, 9, 0, 1'b0, 8'd0);
      @(negedge clk);

      // mode change and second start while busy are ignored
      run_sweep(2, 2'b01, 8'b0000_1000, 9, 2, 1'b0, 8'd0);
      @(negedge clk);

`ifdef NAND_SWEEP_FAULT_INJECT_EN
      // injected fault at vec 2 under NOR, then back-to-back clean sweep
      run_sweep(2, 2'b10, 8'b0000_0001, 9, 0, 1'b1, 8'd2);
      run_sweep(2, 2'b10, 8'b0000_0001, 9, 0, 1'b0, 8'd0);
      @(negedge clk);
`endif

      // randomized sweeps against the reference model
      for (int it = 0; it < 16; it++) begin
         d  = ($urandom_range(0, 1) == 0) ? 2 : 3;
         m  = 2'($urandom);
         nm = $urandom_range(0, 1);
         zp = '0;
         for (int v = 0; v < (1 << d); v++) zp[v] = gold(m, v, d);
         fen = 1'b0;
         fv  = '0;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
         fen = 1'($urandom);
         fv  = 8'($urandom_range(0, (1 << d) - 1));
`endif
         run_sweep(d, m, zp, (1 << (d + 1)) + 1, nm, fen, fv);
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
